fc_tile_sched: RTL and testbench

- Sequences the FC input-address generator and PE array across all tilings of one fully-connected layer.
- Per tiling: loads the start address and first/last-tiling flags and pulses the AGU start, then issues one group-start per input×output piece.
- Each group-start waits for PE readiness and completion. Sits between the layer-level instruction decoder and the FC AGU/PE datapath.

---
 rtl/fc_sched_pkg.sv | 20 ++
 rtl/fc_tile_addr_acc.sv | 34 +++
 rtl/fc_tile_sched.sv | 196 +++++++++++++++++++
 tb/tb_fc_tile_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_sched_pkg.sv
// fc_sched_pkg: shared widths, FSM state encoding and timing constants for the
// FC tiling scheduler.
package fc_sched_pkg;

  localparam int ADDR_W        = 12;
  localparam int PIECE_W       = 8;
  localparam int TILE_W        = 8;
  localparam int GRP_W         = 2 * PIECE_W;
  localparam int SETTLE_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_TILE_START = 3'd1,
    S_SETTLE     = 3'd2,
    S_ISSUE      = 3'd3,
    S_WAIT       = 3'd4,
    S_DONE       = 3'd5
  } state_e;

endpackage

// File: rtl/fc_tile_addr_acc.sv
// fc_tile_addr_acc: tiling start-address accumulator. Loads the base address
// and stride at layer start, then adds the stride on every tiling advance.
// The sum wraps naturally modulo 2^ADDR_W.
module fc_tile_addr_acc
  import fc_sched_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_stride,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;

  // Accumulate the per-tiling start address.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else if (i_load) begin
      addr_q   <= i_base;
      stride_q <= i_stride;
    end else if (i_step) begin
      addr_q   <= addr_q + stride_q;
    end
  end

  assign o_addr = addr_q;

endmodule

// File: rtl/fc_tile_sched.sv
// fc_tile_sched: walks all tilings of one FC layer, starting the AGU once per
// tiling and issuing one group-start per input x output piece.
// Optional build macro FC_SCHED_PERF_EN adds o_StallCnt (ISSUE stall cycles).
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for i_LayerStart; outputs hold last layer's values
// S_TILE_START | o_AGUStart high, flags/address valid for this tiling
// S_SETTLE     | fixed wait covering the AGU first-group latency
// S_ISSUE      | waiting for AGU and PE readiness to issue a group
// S_WAIT       | group in flight, waiting for i_PE_GroupDone
// S_DONE       | layer finished; o_LayerDone is raised on exit
module fc_tile_sched
  import fc_sched_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_LayerStart,
  input  logic [TILE_W-1:0]  i_TileNum,
  input  logic [ADDR_W-1:0]  i_BaseAdder,
  input  logic [ADDR_W-1:0]  i_TileStride,
  input  logic [PIECE_W-1:0] i_Input_PieceNum,
  input  logic [PIECE_W-1:0] i_Out_PieceNum,
  input  logic               i_PreComp_Rdy,
  input  logic               i_PE_Ready,
  input  logic               i_PE_GroupDone,
  output logic               o_AGUStart,
  output logic [ADDR_W-1:0]  o_StartAdder,
  output logic [PIECE_W-1:0] o_Input_PieceNum,
  output logic [PIECE_W-1:0] o_Out_PieceNum,
  output logic               o_bFirstTiling,
  output logic               o_bLastTiling,
  output logic               o_GroupStart,
  output logic               o_Busy,
  output logic               o_LayerDone,
  output logic               o_CfgErr
`ifdef FC_SCHED_PERF_EN
  ,
  output logic [15:0]        o_StallCnt
`endif
);

  state_e             state_q;
  logic [TILE_W-1:0]  tile_num_q;
  logic [TILE_W-1:0]  tile_q;
  logic [TILE_W-1:0]  tile_d;
  logic [GRP_W-1:0]   grp_total_q;
  logic [GRP_W-1:0]   grp_cnt_q;
  logic [GRP_W-1:0]   grp_cnt_d;
  logic [1:0]         settle_q;
  logic               agu_start_q;
  logic               first_q;
  logic               last_q;
  logic               grp_start_q;
  logic               busy_q;
  logic               done_q;
  logic               cfg_err_q;
  logic [PIECE_W-1:0] in_pn_q;
  logic [PIECE_W-1:0] out_pn_q;
`ifdef FC_SCHED_PERF_EN
  logic [15:0]        stall_q;
`endif

  logic cfg_bad;
  logic issue_ok;
  logic acc_load;
  logic acc_step;

  assign tile_d    = tile_q + TILE_W'(1);
  assign grp_cnt_d = grp_cnt_q + GRP_W'(1);
  assign cfg_bad   = (i_TileNum == '0) | (i_Input_PieceNum == '0) | (i_Out_PieceNum == '0);
  assign issue_ok  = i_PreComp_Rdy & i_PE_Ready;

  // The accumulator moves in lockstep with the FSM's layer-start and tile-advance edges.
  assign acc_load = (state_q == S_IDLE) & i_LayerStart;
  assign acc_step = (state_q == S_WAIT) & i_PE_GroupDone & (grp_cnt_d == grp_total_q) & ~last_q;

  fc_tile_addr_acc u_addr_acc (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (acc_load),
    .i_step   (acc_step),
    .i_base   (i_BaseAdder),
    .i_stride (i_TileStride),
    .o_addr   (o_StartAdder)
  );

  // Layer/tiling/group sequencer with registered control outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      tile_num_q  <= '0;
      tile_q      <= '0;
      grp_total_q <= '0;
      grp_cnt_q   <= '0;
      settle_q    <= '0;
      agu_start_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      grp_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      in_pn_q     <= '0;
      out_pn_q    <= '0;
`ifdef FC_SCHED_PERF_EN
      stall_q     <= '0;
`endif
    end else begin
      agu_start_q <= 1'b0;
      grp_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_LayerStart) begin
            tile_num_q  <= i_TileNum;
            in_pn_q     <= i_Input_PieceNum;
            out_pn_q    <= i_Out_PieceNum;
            grp_total_q <= GRP_W'(i_Input_PieceNum) * GRP_W'(i_Out_PieceNum);
            tile_q      <= '0;
            grp_cnt_q   <= '0;
            busy_q      <= 1'b1;
            cfg_err_q   <= cfg_bad;
`ifdef FC_SCHED_PERF_EN
            stall_q     <= '0;
`endif
            if (cfg_bad) begin
              state_q <= S_DONE;
            end else begin
              agu_start_q <= 1'b1;
              first_q     <= 1'b1;
              last_q      <= (i_TileNum == TILE_W'(1));
              state_q     <= S_TILE_START;
            end
          end
        end
        S_TILE_START: begin
          grp_cnt_q <= '0;
          settle_q  <= 2'(SETTLE_CYCLES - 1);
          state_q   <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == '0) state_q <= S_ISSUE;
          else                settle_q <= settle_q - 2'd1;
        end
        S_ISSUE: begin
          if (issue_ok) begin
            grp_start_q <= 1'b1;
            state_q     <= S_WAIT;
          end
`ifdef FC_SCHED_PERF_EN
          else if (stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
          end
`endif
        end
        S_WAIT: begin
          if (i_PE_GroupDone) begin
            grp_cnt_q <= grp_cnt_d;
            if (grp_cnt_d != grp_total_q) begin
              state_q <= S_ISSUE;
            end else if (last_q) begin
              state_q <= S_DONE;
            end else begin
              tile_q      <= tile_d;
              agu_start_q <= 1'b1;
              first_q     <= 1'b0;
              last_q      <= (tile_d == tile_num_q - TILE_W'(1));
              state_q     <= S_TILE_START;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_AGUStart       = agu_start_q;
  assign o_Input_PieceNum = in_pn_q;
  assign o_Out_PieceNum   = out_pn_q;
  assign o_bFirstTiling   = first_q;
  assign o_bLastTiling    = last_q;
  assign o_GroupStart     = grp_start_q;
  assign o_Busy           = busy_q;
  assign o_LayerDone      = done_q;
  assign o_CfgErr         = cfg_err_q;
`ifdef FC_SCHED_PERF_EN
  assign o_StallCnt       = stall_q;
`endif

endmodule

// File: tb/tb_fc_tile_sched.sv
// tb_fc_tile_sched: directed self-checking bench for fc_tile_sched.
// Build with FC_SCHED_PERF_EN defined to also check o_StallCnt.
module tb_fc_tile_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        layer_start;
  logic [7:0]  tile_num;
  logic [11:0] base_addr;
  logic [11:0] stride;
  logic [7:0]  in_pn;
  logic [7:0]  out_pn;
  logic        precomp_rdy;
  logic        pe_ready;
  logic        pe_done_auto;
  logic        pe_done_stray;
  logic        pe_done;
  logic        agu_start;
  logic [11:0] start_addr;
  logic [7:0]  in_pn_o;
  logic [7:0]  out_pn_o;
  logic        first_t;
  logic        last_t;
  logic        grp_start;
  logic        busy;
  logic        layer_done;
  logic        cfg_err;
`ifdef FC_SCHED_PERF_EN
  logic [15:0] stall_cnt;
`endif

  assign pe_done = pe_done_auto | pe_done_stray;

  fc_tile_sched dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_LayerStart     (layer_start),
    .i_TileNum        (tile_num),
    .i_BaseAdder      (base_addr),
    .i_TileStride     (stride),
    .i_Input_PieceNum (in_pn),
    .i_Out_PieceNum   (out_pn),
    .i_PreComp_Rdy    (precomp_rdy),
    .i_PE_Ready       (pe_ready),
    .i_PE_GroupDone   (pe_done),
    .o_AGUStart       (agu_start),
    .o_StartAdder     (start_addr),
    .o_Input_PieceNum (in_pn_o),
    .o_Out_PieceNum   (out_pn_o),
    .o_bFirstTiling   (first_t),
    .o_bLastTiling    (last_t),
    .o_GroupStart     (grp_start),
    .o_Busy           (busy),
    .o_LayerDone      (layer_done),
    .o_CfgErr         (cfg_err)
`ifdef FC_SCHED_PERF_EN
    ,
    .o_StallCnt       (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  int agu_cnt = 0;
  int gs_cnt = 0;
  int done_cnt = 0;
  int gs_first = -1;
  int done_cyc = -1;
  logic busy_at_done = 1'b0;
  int agu_cyc [8];
  logic [11:0] addr_log [8];
  logic first_log [8];
  logic last_log [8];
  int gs_at_agu [8];

  int auto_en = 1;
  int pend = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // PE model: done pulse 3 cycles after each group-start.
  always @(posedge clk) begin
    #1;
    pe_done_auto = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) pe_done_auto = 1'b1;
    end
    if (grp_start && auto_en != 0) pend = 3;
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (agu_start) begin
      if (agu_cnt < 8) begin
        agu_cyc[agu_cnt]   = cyc;
        addr_log[agu_cnt]  = start_addr;
        first_log[agu_cnt] = first_t;
        last_log[agu_cnt]  = last_t;
        gs_at_agu[agu_cnt] = gs_cnt;
      end
      agu_cnt++;
    end
    if (grp_start) begin
      if (gs_cnt == 0) gs_first = cyc;
      gs_cnt++;
    end
    if (layer_done) begin
      done_cyc     = cyc;
      busy_at_done = busy;
      done_cnt++;
    end
  end

  task automatic clear_mon();
    agu_cnt  = 0;
    gs_cnt   = 0;
    done_cnt = 0;
    gs_first = -1;
    done_cyc = -1;
  endtask

  task automatic start_layer(input logic [7:0] tn, input logic [7:0] pi, input logic [7:0] po,
                             input logic [11:0] b, input logic [11:0] s);
    @(posedge clk); #1;
    tile_num    = tn;
    in_pn       = pi;
    out_pn      = po;
    base_addr   = b;
    stride      = s;
    layer_start = 1'b1;
    t0          = cyc;
    @(posedge clk); #1;
    layer_start = 1'b0;
  endtask

  task automatic wait_layer(input string tag, input int max_cyc);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_done_seen"}, done_cnt - d0, 1);
  endtask

  initial begin
    rst = 1'b1; layer_start = 1'b0; tile_num = '0; base_addr = '0; stride = '0;
    in_pn = '0; out_pn = '0; precomp_rdy = 1'b1; pe_ready = 1'b1;
    pe_done_stray = 1'b0; pe_done_auto = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_outs", {agu_start, start_addr, in_pn_o, out_pn_o, first_t, last_t,
                       grp_start, busy, layer_done, cfg_err}, 0);

    // Basic: 2 tilings x (2 x 3) groups.
    clear_mon();
    start_layer(8'd2, 8'd2, 8'd3, 12'h100, 12'h040);
    chk("basic_busy", busy, 1);
    wait_layer("basic", 200);
    chk("basic_agu_cnt", agu_cnt, 2);
    chk("basic_agu0_cyc", agu_cyc[0], t0 + 1);
    chk("basic_agu1_cyc", agu_cyc[1], t0 + 34);
    chk("basic_gs_tile0", gs_at_agu[1], 6);
    chk("basic_gs_total", gs_cnt, 12);
    chk("basic_addr0", addr_log[0], 12'h100);
    chk("basic_addr1", addr_log[1], 12'h140);
    chk("basic_flags0", {first_log[0], last_log[0]}, 2'b10);
    chk("basic_flags1", {first_log[1], last_log[1]}, 2'b01);
    chk("basic_done_cyc", done_cyc, t0 + 68);
    chk("basic_busy_at_done", busy_at_done, 0);
    chk("basic_pieces", {in_pn_o, out_pn_o}, 16'h0203);
    chk("basic_hold_addr", start_addr, 12'h140);

    // Address wrap over 3 tilings.
    clear_mon();
    start_layer(8'd3, 8'd1, 8'd1, 12'hFC0, 12'h080);
    wait_layer("wrap", 200);
    chk("wrap_agu_cnt", agu_cnt, 3);
    chk("wrap_addr0", addr_log[0], 12'hFC0);
    chk("wrap_addr1", addr_log[1], 12'h040);
    chk("wrap_addr2", addr_log[2], 12'h0C0);
    chk("wrap_first", {first_log[0], first_log[1], first_log[2]}, 3'b100);
    chk("wrap_last", {last_log[0], last_log[1], last_log[2]}, 3'b001);
    chk("wrap_hold_addr", start_addr, 12'h0C0);

    // Backpressure: PE not ready for the first 5 ISSUE cycles (T+4..T+8).
    clear_mon();
    pe_ready = 1'b0;
    start_layer(8'd1, 8'd1, 8'd1, 12'h010, 12'h000);
    while (cyc < t0 + 9) begin
      @(posedge clk); #1;
    end
    chk("bp_no_gs_while_low", gs_cnt, 0);
    pe_ready = 1'b1;
    wait_layer("bp", 100);
    chk("bp_gs_cyc", gs_first, t0 + 10);
    chk("bp_single_flags", {first_log[0], last_log[0]}, 2'b11);
`ifdef FC_SCHED_PERF_EN
    chk("bp_stall_cnt", stall_cnt, 5);
`endif

    // Config error then recovery.
    clear_mon();
    start_layer(8'd2, 8'd2, 8'd0, 12'h300, 12'h010);
    chk("cfg_err_set", cfg_err, 1);
    wait_layer("cfg", 20);
    chk("cfg_no_agu", agu_cnt, 0);
    chk("cfg_done_cyc", done_cyc, t0 + 2);
    chk("cfg_err_sticky", cfg_err, 1);
    clear_mon();
    start_layer(8'd1, 8'd1, 8'd1, 12'h020, 12'h000);
    chk("cfg_err_cleared", cfg_err, 0);
    wait_layer("cfg_ok", 100);
    chk("cfg_ok_gs", gs_cnt, 1);

    // Spurious layer-start and group-done during SETTLE and ISSUE.
    clear_mon();
    start_layer(8'd2, 8'd1, 8'd2, 12'h400, 12'h008);
    @(posedge clk); #1;                    // T+2, SETTLE
    tile_num = 8'd5; in_pn = 8'd7;
    layer_start = 1'b1; pe_done_stray = 1'b1;
    @(posedge clk); #1;                    // T+3
    layer_start = 1'b0; pe_done_stray = 1'b0;
    @(posedge clk); #1;                    // T+4, ISSUE
    layer_start = 1'b1; pe_done_stray = 1'b1;
    @(posedge clk); #1;
    layer_start = 1'b0; pe_done_stray = 1'b0;
    wait_layer("spur", 200);
    chk("spur_agu_cnt", agu_cnt, 2);
    chk("spur_gs_total", gs_cnt, 4);
    chk("spur_addr1", addr_log[1], 12'h408);
    chk("spur_in_pn", in_pn_o, 8'd1);

    // Mid-layer reset in WAIT of tiling 1, then a clean layer.
    begin
      int n = 0;
      clear_mon();
      start_layer(8'd2, 8'd1, 8'd1, 12'h500, 12'h100);
      while (gs_cnt < 2 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk("mid_in_tile1", agu_cnt, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_reset_outs", {agu_start, start_addr, in_pn_o, out_pn_o, first_t, last_t,
                             grp_start, busy, layer_done, cfg_err}, 0);
      repeat (10) @(posedge clk);
      #1;
      chk("mid_no_done", done_cnt, 0);
      clear_mon();
      start_layer(8'd2, 8'd1, 8'd1, 12'h200, 12'h010);
      wait_layer("mid_new", 200);
      chk("mid_new_addr0", addr_log[0], 12'h200);
      chk("mid_new_addr1", addr_log[1], 12'h210);
      chk("mid_new_first0", first_log[0], 1);
      chk("mid_new_gs", gs_cnt, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
